// File: rtl/servo_motion_sequencer_pkg.sv
// Shared types and helpers for the servo motion sequencer: angle type, sequencer
// state encoding, target clamping and the per-frame slew arithmetic.
package servo_pkg;

  localparam int N_SERVO   = 4;
  localparam int ANGLE_W   = 8;
  localparam int MAX_ANGLE = 180;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STEP0 = 3'd1,
    S_STEP1 = 3'd2,
    S_STEP2 = 3'd3,
    S_STEP3 = 3'd4,
    S_LOAD  = 3'd5
  } seq_state_t;

  function automatic angle_t clamp_angle(input angle_t a);
    return (a > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : a;
  endfunction

  // Moves cur toward tgt by at most step; the step is capped by the remaining
  // distance so the result lands on the target rather than crossing it.
  function automatic angle_t slew_step(input angle_t cur, input angle_t tgt,
                                       input logic [8:0] step);
    logic [8:0] c9;
    logic [8:0] t9;
    logic [8:0] d9;
    logic [8:0] r9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    d9 = '0;
    r9 = c9;
    if (c9 < t9) begin
      d9 = t9 - c9;
      r9 = c9 + ((d9 < step) ? d9 : step);
    end else if (c9 > t9) begin
      d9 = c9 - t9;
      r9 = c9 - ((d9 < step) ? d9 : step);
    end
    return angle_t'(r9);
  endfunction

endpackage

// File: rtl/servo_motion_sequencer_if.sv
// Command port of the motion sequencer. Handshake: a command transfers on every
// rising clk edge where cmd_valid and cmd_ready are both 1; data is held with valid.
interface servo_motion_sequencer_if;
  import servo_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_servo;
  angle_t     cmd_angle;

  modport master (output cmd_valid, output cmd_servo, output cmd_angle, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_servo, input cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_motion_sequencer_timer.sv
// Free-running frame counter 0..FRAME_CYCLES-1; tick marks the last cycle of a frame.
// Also usable as the period timer of the PWM stage.
module servo_frame_timer #(
  parameter int FRAME_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = $clog2(FRAME_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(FRAME_CYCLES - 1));
  assign tick   = w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/servo_motion_sequencer.sv
// Rate-limited motion controller: once per enabled frame, slews each servo's current
// angle toward its target by at most STEP_DEG and strobes the results to the PWM stage.
module servo_motion_sequencer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int STEP_DEG     = 1,
  parameter int HOME_ANGLE   = 90
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  servo_motion_sequencer_if.slave   cmd,
  output logic                      nextangle,
  output angle_t                    angle1,
  output angle_t                    angle2,
  output angle_t                    angle3,
  output angle_t                    angle4,
  output logic                      busy,
  output seq_state_t                o_dbg_state
);
  localparam angle_t     HOME  = angle_t'(HOME_ANGLE);
  localparam logic [8:0] STEP9 = 9'(STEP_DEG);

  logic       w_tick;
  logic       w_accept;
  logic [1:0] w_idx;
  angle_t     w_stepped;
  logic       w_busy;

  seq_state_t r_state;
  logic       r_cmd_ready;
  logic       r_nextangle;
  angle_t     r_tgt   [N_SERVO];
  angle_t     r_cur   [N_SERVO];
  angle_t     r_angle [N_SERVO];

  servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_accept = cmd.cmd_valid & r_cmd_ready;

  // The step state selects which servo is being slewed this cycle.
  always_comb begin
    w_idx = 2'd0;
    case (r_state)
      S_STEP1: w_idx = 2'd1;
      S_STEP2: w_idx = 2'd2;
      S_STEP3: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
    w_stepped = slew_step(r_cur[w_idx], r_tgt[w_idx], STEP9);
  end

  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < N_SERVO; i++) begin
      if (r_cur[i] != r_tgt[i]) w_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_nextangle <= 1'b0;
      for (int i = 0; i < N_SERVO; i++) begin
        r_tgt[i]   <= HOME;
        r_cur[i]   <= HOME;
        r_angle[i] <= HOME;
      end
    end else begin
      // Commands are only accepted in IDLE/LOAD, so they never race a step.
      if (w_accept) r_tgt[cmd.cmd_servo] <= clamp_angle(cmd.cmd_angle);
      case (r_state)
        S_IDLE: begin
          r_nextangle <= 1'b0;
          if (w_tick && enable) begin
            r_state     <= S_STEP0;
            r_cmd_ready <= 1'b0;
          end
        end
        S_STEP0: begin
          r_cur[0] <= w_stepped;
          r_state  <= S_STEP1;
        end
        S_STEP1: begin
          r_cur[1] <= w_stepped;
          r_state  <= S_STEP2;
        end
        S_STEP2: begin
          r_cur[2] <= w_stepped;
          r_state  <= S_STEP3;
        end
        S_STEP3: begin
          // Servo 3's fresh value bypasses r_cur so LOAD presents all four at once.
          r_cur[3]    <= w_stepped;
          r_angle[0]  <= r_cur[0];
          r_angle[1]  <= r_cur[1];
          r_angle[2]  <= r_cur[2];
          r_angle[3]  <= w_stepped;
          r_nextangle <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_LOAD;
        end
        S_LOAD: begin
          r_nextangle <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_nextangle <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = r_cmd_ready;
  assign nextangle     = r_nextangle;
  assign angle1        = r_angle[0];
  assign angle2        = r_angle[1];
  assign angle3        = r_angle[2];
  assign angle4        = r_angle[3];
  assign busy          = w_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: two instances (STEP_DEG=1 and STEP_DEG=4) with
// short frames; expected strobe angles are queued as stimulus is driven.
module tb_servo_motion_sequencer;
  import servo_pkg::*;

  localparam int FC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en1   = 1'b0;
  logic en4   = 1'b0;

  always #5 clk = ~clk;

  servo_motion_sequencer_if if1 ();
  servo_motion_sequencer_if if4 ();

  logic       na1, na4, busy1, busy4;
  angle_t     d1_a1, d1_a2, d1_a3, d1_a4;
  angle_t     d4_a1, d4_a2, d4_a3, d4_a4;
  seq_state_t st1, st4;

  servo_motion_sequencer #(.FRAME_CYCLES(FC), .STEP_DEG(1), .HOME_ANGLE(90)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .cmd(if1), .nextangle(na1),
    .angle1(d1_a1), .angle2(d1_a2), .angle3(d1_a3), .angle4(d1_a4),
    .busy(busy1), .o_dbg_state(st1)
  );

  servo_motion_sequencer #(.FRAME_CYCLES(FC), .STEP_DEG(4), .HOME_ANGLE(90)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .cmd(if4), .nextangle(na4),
    .angle1(d4_a1), .angle2(d4_a2), .angle3(d4_a3), .angle4(d4_a4),
    .busy(busy4), .o_dbg_state(st4)
  );

  // Cycle index since reset release; the frame counter equals cyc mod FC.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q1[$];

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {angle_t'(a), angle_t'(b), angle_t'(c), angle_t'(d)};
  endfunction

  task automatic drive_cmd(input int sel, input logic v, input int servo, input int ang);
    if (sel == 1) begin
      if1.cmd_valid = v; if1.cmd_servo = 2'(servo); if1.cmd_angle = angle_t'(ang);
    end else begin
      if4.cmd_valid = v; if4.cmd_servo = 2'(servo); if4.cmd_angle = angle_t'(ang);
    end
  endtask

  task automatic send(input int sel, input int servo, input int ang);
    int guard;
    logic rdy;
    guard = 0;
    @(negedge clk);
    drive_cmd(sel, 1'b1, servo, ang);
    rdy = (sel == 1) ? if1.cmd_ready : if4.cmd_ready;
    while (!rdy && guard < 4 * FC) begin
      @(negedge clk);
      guard++;
      rdy = (sel == 1) ? if1.cmd_ready : if4.cmd_ready;
    end
    if (!rdy) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout got=ready_low exp=ready_high");
    end
    @(negedge clk);
    drive_cmd(sel, 1'b0, 0, 0);
  endtask

  task automatic wait_strobe(input int sel, input string name);
    int guard;
    logic seen;
    logic [31:0] got, exp;
    guard = 0;
    seen  = 1'b0;
    while (!seen && guard < 3 * FC) begin
      @(negedge clk);
      guard++;
      seen = (sel == 1) ? na1 : na4;
    end
    n_checks++;
    got = (sel == 1) ? {d1_a1, d1_a2, d1_a3, d1_a4} : {d4_a1, d4_a2, d4_a3, d4_a4};
    if (!seen) begin
      n_errors++;
      $display("FAIL %s strobe_timeout got=none exp=nextangle", name);
    end else if ((sel == 1) ? (exp_q1.size() == 0) : (exp_q.size() == 0)) begin
      n_errors++;
      $display("FAIL %s unexpected_strobe got=%h exp=none", name, got);
    end else begin
      exp = (sel == 1) ? exp_q1.pop_front() : exp_q.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s angles got=%h exp=%h", name, got, exp);
      end
    end
  endtask

  task automatic wait_phase(input int phase);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((cyc % FC) != phase && guard < 3 * FC);
    if ((cyc % FC) != phase) begin
      n_checks++; n_errors++;
      $display("FAIL wait_phase got=%0d exp=%0d", cyc % FC, phase);
    end
  endtask

  task automatic check_home(input string name);
    n_checks++;
    if ({d4_a1, d4_a2, d4_a3, d4_a4, d1_a1, d1_a2, d1_a3, d1_a4} !== {2{pack4(90, 90, 90, 90)}}) begin
      n_errors++;
      $display("FAIL %s angles got=%h_%h exp=%h", name, {d4_a1, d4_a2, d4_a3, d4_a4},
               {d1_a1, d1_a2, d1_a3, d1_a4}, pack4(90, 90, 90, 90));
    end
    n_checks++;
    if ({na4, na1, busy4, busy1, if4.cmd_ready, if1.cmd_ready} !== 6'b000011) begin
      n_errors++;
      $display("FAIL %s ctrl got=%b exp=000011", name,
               {na4, na1, busy4, busy1, if4.cmd_ready, if1.cmd_ready});
    end
    n_checks++;
    if (st4 !== S_IDLE) begin
      n_errors++;
      $display("FAIL %s state got=%0d exp=%0d", name, st4, S_IDLE);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_home("reset_values");
    rst_n = 1'b1;
    en4   = 1'b1;
    exp_q.push_back(pack4(90, 90, 90, 90));
    wait_strobe(4, "first_strobe");
    n_checks++;
    if (cyc !== FC + 4) begin
      n_errors++;
      $display("FAIL first_strobe_cycle got=%0d exp=%0d", cyc, FC + 4);
    end
    en4 = 1'b0;
  endtask

  task automatic test_slew_up();
    send(1, 0, 95);
    en1 = 1'b1;
    for (int i = 1; i <= 5; i++) exp_q1.push_back(pack4(90 + i, 90, 90, 90));
    for (int i = 1; i <= 5; i++) begin
      wait_strobe(1, "slew_up");
      if (i >= 4) begin
        n_checks++;
        if (busy1 !== (i == 4)) begin
          n_errors++;
          $display("FAIL slew_busy frame=%0d got=%b exp=%b", i, busy1, (i == 4));
        end
      end
    end
    en1 = 1'b0;
  endtask

  task automatic test_clamp_overshoot();
    send(4, 3, 250);
    send(4, 2, 88);
    en4 = 1'b1;
    for (int i = 1; i <= 23; i++)
      exp_q.push_back(pack4(90, 90, 88, (90 + 4 * i > 180) ? 180 : 90 + 4 * i));
    for (int i = 1; i <= 23; i++) begin
      wait_strobe(4, "clamp_overshoot");
      if (i >= 22) begin
        n_checks++;
        if (busy4 !== (i == 22)) begin
          n_errors++;
          $display("FAIL clamp_busy frame=%0d got=%b exp=%b", i, busy4, (i == 22));
        end
      end
    end
    en4 = 1'b0;
  endtask

  task automatic test_handshake();
    en4 = 1'b1;
    wait_phase(FC - 1);
    n_checks++;
    if (if4.cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL ready_at_tick got=%b exp=1", if4.cmd_ready);
    end
    @(negedge clk);
    drive_cmd(4, 1'b1, 0, 100);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      n_checks++;
      if (if4.cmd_ready !== 1'b0) begin
        n_errors++; $display("FAIL ready_step T+%0d got=%b exp=0", k, if4.cmd_ready);
      end
    end
    exp_q.push_back(pack4(90, 90, 88, 180));
    wait_strobe(4, "handshake_frame");
    n_checks++;
    if (if4.cmd_ready !== 1'b1 || (cyc % FC) != 4) begin
      n_errors++;
      $display("FAIL ready_load got=%b@%0d exp=1@4", if4.cmd_ready, cyc % FC);
    end
    @(negedge clk);
    drive_cmd(4, 1'b0, 0, 0);
    exp_q.push_back(pack4(94, 90, 88, 180));
    wait_strobe(4, "handshake_next");
    en4 = 1'b0;
  endtask

  task automatic test_enable_gate();
    logic bad;
    bad = 1'b0;
    repeat (2 * FC) begin
      @(negedge clk);
      if (na4 || {d4_a1, d4_a2, d4_a3, d4_a4} !== pack4(94, 90, 88, 180)) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL enable_gate got=strobe_or_change exp=hold %h", pack4(94, 90, 88, 180));
    end
    en4 = 1'b1;
    exp_q.push_back(pack4(98, 90, 88, 180));
    exp_q.push_back(pack4(100, 90, 88, 180));
    wait_strobe(4, "enable_resume");
    wait_strobe(4, "enable_resume");
    en4 = 1'b0;
    n_checks++;
    if (busy4 !== 1'b0) begin
      n_errors++; $display("FAIL enable_busy got=%b exp=0", busy4);
    end
  endtask

  task automatic test_reset_mid_step();
    logic bad;
    send(4, 1, 10);
    en4 = 1'b1;
    wait_phase(FC - 1);
    wait_phase(2);
    n_checks++;
    if (st4 !== S_STEP2) begin
      n_errors++; $display("FAIL mid_state got=%0d exp=%0d", st4, S_STEP2);
    end
    rst_n = 1'b0;
    #1;
    check_home("async_reset");
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (na4) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++; $display("FAIL reset_hold_strobe got=1 exp=0");
    end
    rst_n = 1'b1;
    exp_q.push_back(pack4(90, 90, 90, 90));
    wait_strobe(4, "post_reset_strobe");
    en4 = 1'b0;
  endtask

  initial begin
    drive_cmd(1, 1'b0, 0, 0);
    drive_cmd(4, 1'b0, 0, 0);
    test_reset();
    test_slew_up();
    test_clamp_overshoot();
    test_handshake();
    test_enable_gate();
    test_reset_mid_step();
    n_checks++;
    if (exp_q.size() != 0 || exp_q1.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size() + exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
